// File: rtl/biriscv_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// biriscv_issue_queue_pkg
// Shared definitions for the dual-ported issue queue: the layout of the 12-bit
// decoded-instruction info field, the stored entry layout {instr, pc, info}
// and a helper that packs the three fields into one entry word.
// -----------------------------------------------------------------------------
package biriscv_issue_queue_pkg;

    localparam int INFO_W = 12;

    // Bit positions inside the packed info field
    localparam int INFO_FAULT_FETCH = 11;
    localparam int INFO_FAULT_PAGE  = 10;
    localparam int INFO_EXEC        = 9;
    localparam int INFO_LSU         = 8;
    localparam int INFO_BRANCH      = 7;
    localparam int INFO_MUL         = 6;
    localparam int INFO_DIV         = 5;
    localparam int INFO_CSR         = 4;
    localparam int INFO_RD_VALID    = 3;
    localparam int INFO_INVALID     = 2;
    localparam int INFO_V_LSU       = 1;
    localparam int INFO_V_ALU       = 0;

    localparam int ENTRY_W = 32 + 32 + INFO_W;

    typedef struct packed {
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [INFO_W-1:0] info;
    } entry_t;

    // Build a stored entry from its fields
    function automatic entry_t entry_pack(input logic [31:0]       instr,
                                          input logic [31:0]       pc,
                                          input logic [INFO_W-1:0] info);
        entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.info  = info;
        return e;
    endfunction

endpackage

// File: rtl/biriscv_issue_queue_ram.sv
// -----------------------------------------------------------------------------
// biriscv_issue_queue_ram
// DEPTH x ENTRY_W register array, 2 write ports, 2 asynchronous read ports.
// Contents are never reset. If both write ports target the same address in
// one cycle, write port 1 wins (the queue never does this).
//
// Ports:
//   clk_i                 clock
//   we0_i/waddr0_i/wdata0_i   write port 0
//   we1_i/waddr1_i/wdata1_i   write port 1 (priority over port 0)
//   raddr0_i/rdata0_o     asynchronous read port 0
//   raddr1_i/rdata1_o     asynchronous read port 1
// -----------------------------------------------------------------------------
module biriscv_issue_queue_ram
    import biriscv_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
)(
    input  logic               clk_i,
    input  logic               we0_i,
    input  logic [DEPTH_W-1:0] waddr0_i,
    input  logic [ENTRY_W-1:0] wdata0_i,
    input  logic               we1_i,
    input  logic [DEPTH_W-1:0] waddr1_i,
    input  logic [ENTRY_W-1:0] wdata1_i,
    input  logic [DEPTH_W-1:0] raddr0_i,
    output logic [ENTRY_W-1:0] rdata0_o,
    input  logic [DEPTH_W-1:0] raddr1_i,
    output logic [ENTRY_W-1:0] rdata1_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Storage write; port 1 is assigned last so it wins on an address clash
    always_ff @(posedge clk_i) begin
        if (we0_i) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we1_i) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/biriscv_issue_queue.sv
// -----------------------------------------------------------------------------
// biriscv_issue_queue
// In-order dual-ported instruction queue between decode and issue. Accepts
// 0-2 instructions per cycle (slot 0 older) and presents the two oldest
// entries to issue. Flush drops all held entries.
//
// Optional feature: define BIRISCV_ISSUE_QUEUE_BYPASS_EN to forward the inputs
// combinationally to the outputs while the queue is empty (zero latency).
//
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   in0_*/in1_*    : valid, instr, pc, info in; accept out (state-only)
//   out0_*/out1_*  : valid, instr, pc, info out; accept in
//                    (out1 accept is honoured only together with out0 accept)
//   level_o        : number of occupied entries
// -----------------------------------------------------------------------------
module biriscv_issue_queue
    import biriscv_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in0_valid_i,
    input  logic [31:0]       in0_instr_i,
    input  logic [31:0]       in0_pc_i,
    input  logic [INFO_W-1:0] in0_info_i,
    output logic              in0_accept_o,
    input  logic              in1_valid_i,
    input  logic [31:0]       in1_instr_i,
    input  logic [31:0]       in1_pc_i,
    input  logic [INFO_W-1:0] in1_info_i,
    output logic              in1_accept_o,
    output logic              out0_valid_o,
    output logic [31:0]       out0_instr_o,
    output logic [31:0]       out0_pc_o,
    output logic [INFO_W-1:0] out0_info_o,
    input  logic              out0_accept_i,
    output logic              out1_valid_o,
    output logic [31:0]       out1_instr_o,
    output logic [31:0]       out1_pc_o,
    output logic [INFO_W-1:0] out1_info_o,
    input  logic              out1_accept_i,
    output logic [DEPTH_W:0]  level_o
);

    localparam logic [DEPTH_W:0] DEPTH_C    = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W:0] DEPTH_M1_C = (DEPTH_W+1)'(DEPTH - 1);

    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W:0]   count_q,  count_d;

    entry_t in0_entry_s, in1_entry_s;
    entry_t rd0_entry_s, rd1_entry_s;
    entry_t out0_entry_s, out1_entry_s;

    logic               byp_s;
    logic               push0_s, push1_s, pop0_s, pop1_s;
    logic               wr0_s, wr1_s;
    logic [1:0]         n_wr_s, n_rd_s;
    logic [DEPTH_W-1:0] waddr1_s;
    logic [DEPTH_W-1:0] raddr1_s;

    assign in0_entry_s = entry_pack(in0_instr_i, in0_pc_i, in0_info_i);
    assign in1_entry_s = entry_pack(in1_instr_i, in1_pc_i, in1_info_i);

    // Accepts look at registered occupancy only
    assign in0_accept_o = ~rst_i & (count_q < DEPTH_C);
    assign in1_accept_o = ~rst_i & (count_q < DEPTH_M1_C);

`ifdef BIRISCV_ISSUE_QUEUE_BYPASS_EN
    assign byp_s = (count_q == {(DEPTH_W+1){1'b0}});
`else
    assign byp_s = 1'b0;
`endif

    assign raddr1_s = rd_ptr_q + {{(DEPTH_W-1){1'b0}}, 1'b1};

    // Output selection, pop/push decode and next-state computation
    always_comb begin
        push0_s = in0_valid_i & in0_accept_o;
        push1_s = in1_valid_i & in1_accept_o;

        if (byp_s) begin
            out0_valid_o = push0_s;
            out1_valid_o = push1_s;
            out0_entry_s = in0_entry_s;
            out1_entry_s = in1_entry_s;
        end else begin
            out0_valid_o = (count_q != {(DEPTH_W+1){1'b0}});
            out1_valid_o = (count_q > {{DEPTH_W{1'b0}}, 1'b1});
            out0_entry_s = rd0_entry_s;
            out1_entry_s = rd1_entry_s;
        end

        pop0_s = out0_valid_o & out0_accept_i;
        pop1_s = out1_valid_o & out1_accept_i & pop0_s;

        // Instructions consumed straight through the bypass are never stored
        wr0_s = push0_s & ~(byp_s & pop0_s) & ~flush_i;
        wr1_s = push1_s & ~(byp_s & pop1_s) & ~flush_i;

        n_wr_s = {1'b0, wr0_s} + {1'b0, wr1_s};
        if (byp_s) begin
            n_rd_s = 2'd0;
        end else begin
            n_rd_s = {1'b0, pop0_s} + {1'b0, pop1_s};
        end

        // Slot 1 lands right after slot 0 only if slot 0 was written
        waddr1_s = wr_ptr_q + {{(DEPTH_W-1){1'b0}}, wr0_s};

        if (rst_i || flush_i) begin
            rd_ptr_d = {DEPTH_W{1'b0}};
            wr_ptr_d = {DEPTH_W{1'b0}};
            count_d  = {(DEPTH_W+1){1'b0}};
        end else begin
            rd_ptr_d = rd_ptr_q + DEPTH_W'(n_rd_s);
            wr_ptr_d = wr_ptr_q + DEPTH_W'(n_wr_s);
            count_d  = count_q + (DEPTH_W+1)'(n_wr_s) - (DEPTH_W+1)'(n_rd_s);
        end
    end

    assign out0_instr_o = out0_entry_s.instr;
    assign out0_pc_o    = out0_entry_s.pc;
    assign out0_info_o  = out0_entry_s.info;
    assign out1_instr_o = out1_entry_s.instr;
    assign out1_pc_o    = out1_entry_s.pc;
    assign out1_info_o  = out1_entry_s.info;
    assign level_o      = count_q;

    // Pointer and occupancy state (reset/flush folded into *_d)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= {DEPTH_W{1'b0}};
            wr_ptr_q <= {DEPTH_W{1'b0}};
            count_q  <= {(DEPTH_W+1){1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    biriscv_issue_queue_ram #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_ram (
        .clk_i    (clk_i),
        .we0_i    (wr0_s),
        .waddr0_i (wr_ptr_q),
        .wdata0_i (in0_entry_s),
        .we1_i    (wr1_s),
        .waddr1_i (waddr1_s),
        .wdata1_i (in1_entry_s),
        .raddr0_i (rd_ptr_q),
        .rdata0_o (rd0_entry_s),
        .raddr1_i (raddr1_s),
        .rdata1_o (rd1_entry_s)
    );

endmodule

// File: doc/biriscv_issue_queue.md
Name: biriscv_issue_queue

Overview:
Dual-ported instruction queue placed directly downstream of the frontend's two decoded fetch outputs (fetch0/fetch1) and feeding the issue stage. It takes 0–2 decoded instructions per cycle and delivers up to 2 per cycle in program order, so stalls in the issue stage are decoupled from the fetch/decode pipeline. A flush discards everything held when a branch or exception redirect occurs.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 4.
- DEPTH_W, 3, log2(DEPTH).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all entries (pipeline redirect).
- in0_valid_i  in  1  slot-0 instruction present (older).
- in0_instr_i  in  32  slot-0 opcode.
- in0_pc_i  in  32  slot-0 PC.
- in0_info_i  in  12  slot-0 packed bits: {fault_fetch, fault_page, exec, lsu, branch, mul, div, csr, rd_valid, invalid, v_lsu, v_alu}.
- in0_accept_o  out  1  slot 0 is taken this cycle if valid.
- in1_valid_i / in1_instr_i / in1_pc_i / in1_info_i  in  1/32/32/12  slot-1 instruction (younger); same layout as slot 0.
- in1_accept_o  out  1  slot 1 is taken this cycle if valid.
- out0_valid_o / out0_instr_o / out0_pc_o / out0_info_o  out  1/32/32/12  oldest entry.
- out0_accept_i  in  1  issue consumes out0.
- out1_valid_o / out1_instr_o / out1_pc_o / out1_info_o  out  1/32/32/12  second-oldest entry.
- out1_accept_i  in  1  issue consumes out1; only honoured together with out0_accept_i.
- level_o  out  DEPTH_W+1  current number of occupied entries.

Behaviour:
- State consists of the storage array, rd_ptr and wr_ptr (each DEPTH_W bits, wrapping modulo DEPTH), and count (DEPTH_W+1 bits).
- Reset or flush (synchronous): rd_ptr=0, wr_ptr=0, count=0. All out*_valid_o=0 in the following cycle. Storage contents are not cleared.
- Flush has priority: pushes and pops in the flush cycle are dropped.
- Accepts depend on registered state only; there is no combinational path from valid to accept.
  - in0_accept_o = (DEPTH-count >= 1).
  - in1_accept_o = (DEPTH-count >= 2).
  - Both are 0 during rst_i.
- Push:
  - push0 = in0_valid_i & in0_accept_o.
  - push1 = in1_valid_i & in1_accept_o.
  - Slot 0 writes at wr_ptr. Slot 1 writes at wr_ptr+push0, so order is preserved even when in0 is not valid.
  - wr_ptr advances by push0+push1.
- Pop:
  - out0_valid_o = (count>=1), driven from rd_ptr.
  - out1_valid_o = (count>=2), driven from rd_ptr+1.
  - pop0 = out0_valid_o & out0_accept_i.
  - pop1 = out1_valid_o & out1_accept_i & pop0. out1_accept_i without out0_accept_i is ignored.
  - rd_ptr advances by pop0+pop1.
- count_next = count + push0 + push1 − pop0 − pop1. Simultaneous push and pop is legal at any level. Space freed by a pop is not visible to the accepts until the next cycle.
- Latency, baseline: a written entry appears on the outputs the next cycle.
- Boundary conditions:
  - Full (count=DEPTH): both accepts are 0.
  - count=DEPTH−1: only slot 0 is accepted.
  - Empty: both outputs are invalid.
  - Pointer wrap is a natural modulo-DEPTH overflow.
- Output data when out*_valid_o=0 is don't-care.

Optional Feature:
- Macro: BIRISCV_ISSUE_QUEUE_BYPASS_EN.
- Defined: when count==0, in0/in1 are forwarded combinationally to out0/out1 (out*_valid_o = in*_valid_o & accept).
  - Bypassed instructions consumed that cycle are not written.
  - Unconsumed ones are written in order at wr_ptr.
  - This gives zero-cycle latency through an empty queue.
  - It adds an in→out combinational path but still no path from valid to accept.
- Undefined: no combinational path from inputs to outputs; minimum latency is 1 cycle.

Decomposition:
- Package biriscv_issue_queue_pkg holds:
  - INFO_W=12 and the bit-index localparams of the info fields (INFO_FAULT_FETCH=11 … INFO_V_ALU=0).
  - ENTRY_W=76, the entry layout {instr, pc, info}.
- Sub-module biriscv_issue_queue_ram: DEPTH×ENTRY_W register array with 2 write ports and 2 asynchronous read ports. When both write ports hit the same address, write port 1 wins; this cannot occur in legal operation.

Test Plan:
- Reset, then push in0 (pc=0x80000000, instr=0x00000013) with out accepts low → next cycle out0_valid_o=1, pc=0x80000000, level_o=1, out1_valid_o=0.
- Push pairs every cycle with accepts low → after 4 cycles level_o=8 and in0_accept_o=in1_accept_o=0. Pop a single entry → the next cycle gives in0_accept_o=1, in1_accept_o=0.
- Fill with 6 entries, assert out1_accept_i=1 and out0_accept_i=0 → no pop, level stays 6. Assert both → level 4, with PCs in order.
- Drive 20 pairs while popping 2 per cycle so pointers wrap more than twice → PC sequence out equals sequence in, with no loss or duplication.
- At level 5, assert flush_i together with in0/in1 valid and out0_accept_i → next cycle level_o=0 and both outputs invalid.
- With BIRISCV_ISSUE_QUEUE_BYPASS_EN defined, on an empty queue push in0/in1 with out0_accept_i=1 and out1_accept_i=0 → out0 shows in0 in the same cycle; next cycle out0 = former in1, level_o=1.
